// File: rtl/nfca_pkg.sv
// Shared definitions for the NFC-A transceiver arbiter: result codes, FSM
// state encoding, counter width and the 81.36 MHz default cycle counts.
package nfca_pkg;

  localparam int unsigned CNT_W = 24;

  // 5 ms guard, 10 ms TX watchdog / RX window, 100 ms carrier hold
  localparam logic [CNT_W-1:0] GUARD_CYC_DEF   = 24'd406800;
  localparam logic [CNT_W-1:0] TIMEOUT_CYC_DEF = 24'd813600;
  localparam logic [CNT_W-1:0] HOLD_CYC_DEF    = 24'd8136000;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_TIMEOUT = 2'd1,
    RES_RXERR   = 2'd2,
    RES_ABORT   = 2'd3
  } nfca_res_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GUARD   = 3'd1,
    ST_TX_GO   = 3'd2,
    ST_TX_WAIT = 3'd3,
    ST_RX_WAIT = 3'd4,
    ST_END     = 3'd5
  } nfca_state_e;

endpackage

// File: rtl/nfca_txn_arbiter_rr_arb2.sv
// Two-way round-robin pick. The pick is combinational from the live request
// vector; only the "last granted" pointer is stored.
module nfca_rr_arb2
  import nfca_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] upd_gnt_i,
  output logic [1:0] pick_o
);

  // last_q = index of the requester granted most recently
  logic last_q, last_d;

  // Single request wins outright; on a tie the one not served last goes first
  always_comb begin
    pick_o = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = last_q ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
    if (upd_i) last_d = upd_gnt_i[1];
  end

  // Pointer resets to "requester 1 last" so requester 0 is preferred
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/nfca_txn_arbiter.sv
// Shares one NFC-A transceiver core between the UART host path (req 0) and
// the local poll engine (req 1): grants, carrier guard, TX, RX window,
// result report and carrier idle hold.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no grant; arbitrate; carrier hold timer running
// GUARD    | carrier just raised, unmodulated carrier before first TX
// TX_GO    | one cycle; registers the tx_start pulse
// TX_WAIT  | waiting for tx_done, watchdog running
// RX_WAIT  | rx_on high, waiting for rx_done, RX window timer running
// END      | done pulse to granted requester, rr pointer update
module nfca_txn_arbiter
  import nfca_pkg::*;
#(
  parameter logic [CNT_W-1:0] GUARD_CYC   = GUARD_CYC_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [CNT_W-1:0] HOLD_CYC    = HOLD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [1:0] result,
  output logic       busy,
  output logic       carrier_en,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       rx_on,
  input  logic       rx_done,
  input  logic       rx_err
);

  nfca_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  nfca_res_e        result_q, result_d;
  logic             carrier_q, carrier_d;
  logic             abort_q, abort_d;
  logic             tx_start_q;
  logic [1:0]       pick;
  logic             req_g, guard_hit, to_hit, hold_hit;

  assign req_g     = |(req & gnt_q);
  // TX_GO is the last guard cycle, so the guard count starts at 1 and the
  // carrier runs exactly GUARD_CYC cycles before tx_start.
  assign guard_hit = (cnt_q >= (GUARD_CYC - CNT_W'(1)));
  assign to_hit    = (cnt_q == (TIMEOUT_CYC - CNT_W'(1)));
  assign hold_hit  = (cnt_q == (HOLD_CYC - CNT_W'(1)));

  nfca_rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req),
    .upd_i     (state_q == ST_END),
    .upd_gnt_i (gnt_q),
    .pick_o    (pick)
  );

  // Next-state, grant, result and carrier decisions; shared timer reload
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    result_d  = result_q;
    carrier_d = carrier_q;
    abort_d   = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (pick != 2'b00) begin
          gnt_d = pick;
          if (carrier_q) begin
            state_d = ST_TX_GO;
          end else begin
            state_d   = ST_GUARD;
            carrier_d = 1'b1;
          end
        end else if (hold_hit) begin
          carrier_d = 1'b0;
        end
      end
      ST_GUARD: begin
        if (!req_g) begin
          state_d  = ST_END;
          result_d = RES_ABORT;
        end else if (guard_hit) begin
          state_d = ST_TX_GO;
        end
      end
      ST_TX_GO: begin
        state_d = ST_TX_WAIT;
        abort_d = ~req_g;
      end
      ST_TX_WAIT: begin
        // once TX is on air it must finish; a dropped request only marks abort
        abort_d = abort_q | ~req_g;
        if (tx_done) begin
          if (abort_d) begin
            state_d  = ST_END;
            result_d = RES_ABORT;
          end else begin
            state_d = ST_RX_WAIT;
          end
        end else if (to_hit) begin
          state_d  = ST_END;
          result_d = abort_d ? RES_ABORT : RES_TIMEOUT;
        end
      end
      ST_RX_WAIT: begin
        if (rx_done) begin
          state_d  = ST_END;
          result_d = rx_err ? RES_RXERR : RES_OK;
        end else if (!req_g) begin
          state_d  = ST_END;
          result_d = RES_ABORT;
        end else if (to_hit) begin
          state_d  = ST_END;
          result_d = RES_TIMEOUT;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = (state_d == ST_GUARD) ? CNT_W'(1) : '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  // State and output registers; reset drops carrier and kills any transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      result_q   <= RES_OK;
      carrier_q  <= 1'b0;
      abort_q    <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      result_q   <= result_d;
      carrier_q  <= carrier_d;
      abort_q    <= abort_d;
      tx_start_q <= (state_q == ST_TX_GO);
    end
  end

  assign gnt        = gnt_q;
  assign done       = (state_q == ST_END) ? gnt_q : 2'b00;
  assign result     = result_q;
  assign busy       = |gnt_q;
  assign carrier_en = carrier_q;
  assign tx_start   = tx_start_q;
  assign rx_on      = (state_q == ST_RX_WAIT);

endmodule

// File: tb/tb_nfca_txn_arbiter.sv
// Directed bench for nfca_txn_arbiter with GUARD=8, TIMEOUT=20, HOLD=30.
// Inputs change 1 time unit after the rising edge; outputs are read there.
module tb_nfca_txn_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] req = 2'b00;
  logic       tx_done = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_err = 1'b0;
  logic [1:0] gnt, done, result;
  logic       busy, carrier_en, tx_start, rx_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nfca_txn_arbiter #(
    .GUARD_CYC   (24'd8),
    .TIMEOUT_CYC (24'd20),
    .HOLD_CYC    (24'd30)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .carrier_en (carrier_en),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .rx_on      (rx_on),
    .rx_done    (rx_done),
    .rx_err     (rx_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_start(output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // From IDLE with carrier on: grant, tx_start, tx_done; returns in first RX_WAIT cycle
  task automatic start_to_rx(input logic [1:0] r);
    req = r;
    tick();
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({gnt, done, result, busy, carrier_en, tx_start, rx_on} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {gnt, done, result, busy, carrier_en, tx_start, rx_on});
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({gnt, busy, carrier_en, tx_start} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release_idle got %b want 0", {gnt, busy, carrier_en, tx_start});
    end
  endtask

  task automatic test_cold_start();
    int n;
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || carrier_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cold_grant got gnt=%b car=%b busy=%b want 01 1 1", gnt, carrier_en, busy);
    end
    // stray tx_done during guard must be ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    wait_tx_start(n);
    checks++;
    if (n + 2 != 8) begin
      errors++;
      $display("FAIL cold_guard_len got %0d want 8", n + 2);
    end
    tick();
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL cold_tx_start_pulse got %b want 0", tx_start);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (rx_on !== 1'b1) begin
      errors++;
      $display("FAIL cold_rx_on got %b want 1", rx_on);
    end
    repeat (3) tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    checks++;
    if (done !== 2'b01 || result !== 2'd0 || rx_on !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cold_done got done=%b res=%0d rx_on=%b busy=%b want 01 0 0 1", done, result, rx_on, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0 || carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL cold_after_done got done=%b gnt=%b busy=%b car=%b want 00 00 0 1", done, gnt, busy, carrier_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [3] = '{2'b10, 2'b01, 2'b10};
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== exp_g[i] || tx_start !== 1'b0) begin
        errors++;
        $display("FAIL b2b_grant[%0d] got gnt=%b txs=%b want %b 0", i, gnt, tx_start, exp_g[i]);
      end
      tick();
      checks++;
      if (tx_start !== 1'b1) begin
        errors++;
        $display("FAIL b2b_tx_start[%0d] got %b want 1", i, tx_start);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      checks++;
      if (done !== exp_g[i] || result !== 2'd0) begin
        errors++;
        $display("FAIL b2b_done[%0d] got done=%b res=%0d want %b 0", i, done, result, exp_g[i]);
      end
      if (i == 2) req = 2'b00;
      tick();
      checks++;
      if (gnt !== 2'b00 || done !== 2'b00 || carrier_en !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle[%0d] got gnt=%b done=%b car=%b want 00 00 1", i, gnt, done, carrier_en);
      end
    end
  endtask

  task automatic test_rx_timeout();
    int n;
    start_to_rx(2'b01);
    n = 0;
    while (rx_on === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL rx_window_len got %0d want 20", n);
    end
    checks++;
    if (done !== 2'b01 || result !== 2'd1) begin
      errors++;
      $display("FAIL rx_timeout_done got done=%b res=%0d want 01 1", done, result);
    end
    req = 2'b00;
    tick();

    // rx_done in the last window cycle beats the timeout
    start_to_rx(2'b10);
    repeat (19) tick();
    checks++;
    if (rx_on !== 1'b1) begin
      errors++;
      $display("FAIL rx_last_cycle_open got %b want 1", rx_on);
    end
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    checks++;
    if (done !== 2'b10 || result !== 2'd0) begin
      errors++;
      $display("FAIL rx_late_ok got done=%b res=%0d want 10 0", done, result);
    end
    req = 2'b00;
    tick();

    start_to_rx(2'b01);
    tick();
    rx_done = 1'b1;
    rx_err = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_err = 1'b0;
    checks++;
    if (done !== 2'b01 || result !== 2'd2) begin
      errors++;
      $display("FAIL rx_err_result got done=%b res=%0d want 01 2", done, result);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_abort_tx_wait();
    logic seen_rx;
    seen_rx = 1'b0;
    req = 2'b01;
    tick();
    tick();
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL abort_tx_start got %b want 1", tx_start);
    end
    req = 2'b00;
    tick();
    seen_rx |= rx_on;
    tick();
    seen_rx |= rx_on;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 2'b01 || result !== 2'd3 || rx_on !== 1'b0 || seen_rx !== 1'b0) begin
      errors++;
      $display("FAIL abort_tx_wait got done=%b res=%0d rx_on=%b seen_rx=%b want 01 3 0 0", done, result, rx_on, seen_rx);
    end
    tick();
  endtask

  // Ends in the END cycle so the hold test starts right at done
  task automatic test_abort_rx_wait();
    start_to_rx(2'b10);
    tick();
    req = 2'b00;
    tick();
    checks++;
    if (rx_on !== 1'b0 || done !== 2'b10 || result !== 2'd3) begin
      errors++;
      $display("FAIL abort_rx_wait got rx_on=%b done=%b res=%0d want 0 10 3", rx_on, done, result);
    end
  endtask

  task automatic test_carrier_hold();
    int n;
    repeat (30) tick();
    checks++;
    if (carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL hold_last_cycle got %b want 1", carrier_en);
    end
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL hold_rescue got gnt=%b car=%b want 01 1", gnt, carrier_en);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_guard got tx_start=%b want 1", tx_start);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    checks++;
    if (done !== 2'b01 || result !== 2'd0) begin
      errors++;
      $display("FAIL hold_txn_done got done=%b res=%0d want 01 0", done, result);
    end
    req = 2'b00;
    n = 0;
    tick();
    while (carrier_en === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL hold_len got %0d want 30", n);
    end
  endtask

  task automatic test_abort_guard();
    logic seen_tx;
    seen_tx = 1'b0;
    req = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b10 || carrier_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL guard_grant got gnt=%b car=%b busy=%b want 10 1 1", gnt, carrier_en, busy);
    end
    tick();
    req = 2'b00;
    tick();
    seen_tx |= tx_start;
    checks++;
    if (done !== 2'b10 || result !== 2'd3) begin
      errors++;
      $display("FAIL guard_abort got done=%b res=%0d want 10 3", done, result);
    end
    repeat (3) begin
      tick();
      seen_tx |= tx_start;
    end
    checks++;
    if (seen_tx !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL guard_abort_no_tx got seen_tx=%b gnt=%b want 0 00", seen_tx, gnt);
    end
  endtask

  task automatic test_reset_mid_rx();
    int n;
    start_to_rx(2'b01);
    checks++;
    if (rx_on !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_rx_on got %b want 1", rx_on);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, rx_on, carrier_en, done} !== 7'b0) begin
      errors++;
      $display("FAIL rst_async got %b want 0", {gnt, busy, rx_on, carrier_en, done});
    end
    tick();
    checks++;
    if (done !== 2'b00 || result !== 2'd0) begin
      errors++;
      $display("FAIL rst_no_done got done=%b res=%0d want 00 0", done, result);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01 || carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_cold_grant got gnt=%b car=%b want 01 1", gnt, carrier_en);
    end
    wait_tx_start(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL rst_cold_guard got %0d want 8", n);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_cold_start();
    test_back_to_back();
    test_rx_timeout();
    test_abort_tx_wait();
    test_abort_rx_wait();
    test_carrier_hold();
    test_abort_guard();
    test_reset_mid_rx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
